lfsr_burst_ctrl: RTL and testbench
==================================

# lfsr_burst_ctrl

Round-robin controller that shares one NUM_BITS-wide LFSR instance between NUM_REQ requesters. For each granted requester it loads that requester's seed into the LFSR, then streams a burst of pseudo-random words over a valid/ready interface, advancing the LFSR only on accepted words. It sits between the LFSR and its consumers, for example pattern generators, scramblers and test-data sources.

## Interface
- NUM_BITS, 8, LFSR width; must match the attached LFSR instance.
- NUM_REQ, 4, number of requesters, 2..16.
- LEN_W, 8, burst-length field width.
- i_Clk  in  1  clock; all logic is on the rising edge.
- i_Rst_L  in  1  reset, asynchronous assert, active-low.
- i_Req  in  NUM_REQ  level request per requester.
- i_Seed  in  NUM_REQ*NUM_BITS  per-requester seed; requester k occupies slice [k*NUM_BITS +: NUM_BITS].
- i_Len  in  NUM_REQ*LEN_W  per-requester burst length in words; requester k occupies slice [k*LEN_W +: LEN_W].
- o_Grant  out  NUM_REQ  one-hot grant, held for the whole burst.
- o_Busy  out  1  high in SEED and RUN.
- o_Data  out  NUM_BITS  equals i_LFSR_Data (combinational).
- o_Data_Valid  out  1  word valid.
- i_Data_Ready  in  1  consumer accepts the word.
- o_Last  out  1  marks the final word of the burst; qualified by o_Data_Valid.
- o_LFSR_Enable  out  1  drives the LFSR enable.
- o_LFSR_Seed_DV  out  1  drives the LFSR seed load.
- o_LFSR_Seed_Data  out  NUM_BITS  registered seed for the granted requester.
- i_LFSR_Data  in  NUM_BITS  current LFSR register value.

## Operation
- FSM has three states: IDLE, SEED and RUN.
- **IDLE.** If any i_Req bit is high, pick the first set bit scanning upward from (r_Last_Idx+1) mod NUM_REQ.
  - Latch the index, the seed (into o_LFSR_Seed_Data) and the length. A length of 0 is latched as 1.
  - Set r_Last_Idx to the picked index and go to SEED.
- **SEED.** Drive o_Grant, o_LFSR_Enable=1 and o_LFSR_Seed_DV=1 for exactly one cycle, then go to RUN. The LFSR holds the seed from the next cycle.
- **RUN.** Drive o_Data_Valid=1.
  - A handshake is o_Data_Valid & i_Data_Ready.
  - On a handshake: o_LFSR_Enable=1 (combinational, Seed_DV=0) and the word counter increments.
  - o_Last = (count == len-1).
  - On a handshake with o_Last, go to IDLE.
- Without a handshake: o_LFSR_Enable=0 and o_Data stays stable.
- i_Req, i_Seed and i_Len are sampled only in IDLE. Changes during a burst are ignored, except as described under Configuration.
- There is one IDLE cycle between consecutive bursts, so no back-to-back grants.
- Counter width is LEN_W. A length of 2^LEN_W-1 is the maximum burst.

## Timing
- Reset (i_Rst_L low): state goes to IDLE immediately.
  - Reset values: o_Grant=0, o_Busy=0, o_Data_Valid=0, o_Last=0, o_LFSR_Enable=0, o_LFSR_Seed_DV=0, o_LFSR_Seed_Data=0, counter=0, r_Last_Idx=NUM_REQ-1.
  - Requester 0 therefore wins first after reset.
- Latency: i_Req sampled high in IDLE at cycle 0 -> SEED at cycle 1 (o_Grant high) -> first o_Data_Valid at cycle 2 with o_Data = seed.
- With i_Data_Ready held high, a burst of L words occupies cycles 2..L+1, and the next grant can appear at cycle L+3.
- Reset mid-burst: outputs return to reset values asynchronously and the partial burst is discarded.
  - The LFSR itself is not reset; the next burst always reseeds it.
- i_Data_Ready may change in any cycle. Valid never drops in RUN except on burst completion or on abort.

## Configuration
- LFSR_BURST_ABORT_EN defined: if the granted i_Req bit is low during RUN:
  - o_Data_Valid is forced to 0 that cycle and no handshake occurs.
  - The FSM returns to IDLE on the next edge without issuing o_Last.
  - r_Last_Idx still advances.
- LFSR_BURST_ABORT_EN undefined: once granted, the burst always completes regardless of i_Req.

## Test plan
All scenarios use the 8-bit codebase LFSR (XNOR taps 8,6,5,4).
- **Single burst:** req0, seed 0x01, len 3, ready high -> o_Grant=0001 at cycle 1; o_Data 0x01, 0x03, 0x07 in cycles 2-4; o_Last only in cycle 4; idle at cycle 5.
- **Backpressure:** same setup as the single burst, with ready low for 3 cycles while 0x03 is presented -> o_Data holds 0x03, o_LFSR_Enable=0 throughout, and exactly 3 words are transferred.
- **Round-robin:** i_Req=1011 held, all lengths 1 -> grant order 0, 1, 3, 0, 1, each grant separated by SEED, RUN and IDLE cycles.
- **Zero length:** i_Len=0 for req2 -> one word equal to the seed, with o_Last asserted on that word.
- **Async reset:** assert i_Rst_L low in the middle of a RUN -> all outputs go to 0 within the same cycle. After release with req1 only, o_Grant=0010 at cycle 1 and the first word equals req1's seed.
- **Abort (LFSR_BURST_ABORT_EN):** len 5, drop req0 after 2 words -> valid deasserts that cycle, no o_Last, IDLE next cycle, and a pending req1 is granted next.

Source files
------------

// File: rtl/lfsr_burst_ctrl.sv
// Round-robin burst controller sharing one LFSR between requesters.
// Define LFSR_BURST_ABORT_EN to end a burst early when its request drops.
module lfsr_burst_ctrl #(
   parameter int NUM_BITS = 8,
   parameter int NUM_REQ  = 4,
   parameter int LEN_W    = 8
) (
   input  logic                        i_Clk,
   input  logic                        i_Rst_L,
   input  logic [NUM_REQ-1:0]          i_Req,
   input  logic [NUM_REQ*NUM_BITS-1:0] i_Seed,
   input  logic [NUM_REQ*LEN_W-1:0]    i_Len,
   output logic [NUM_REQ-1:0]          o_Grant,
   output logic                        o_Busy,
   output logic [NUM_BITS-1:0]         o_Data,
   output logic                        o_Data_Valid,
   input  logic                        i_Data_Ready,
   output logic                        o_Last,
   output logic                        o_LFSR_Enable,
   output logic                        o_LFSR_Seed_DV,
   output logic [NUM_BITS-1:0]         o_LFSR_Seed_Data,
   input  logic [NUM_BITS-1:0]         i_LFSR_Data
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SEED,
      RUN
   } state_e;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [IDX_W-1:0]    last_idx_q, last_idx_d;
   logic [NUM_BITS-1:0] seed_q, seed_d;
   logic [LEN_W-1:0]    last_cnt_q, last_cnt_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;

   logic                found;
   logic [IDX_W-1:0]    pick;
   logic [IDX_W-1:0]    cand;
   logic [NUM_BITS-1:0] sel_seed;
   logic [LEN_W-1:0]    sel_len;
   logic                abort;
   logic                hs;

   // First requester strictly after the previous winner, wrapping around
   always_comb begin
      found = 1'b0;
      pick  = last_idx_q;
      cand  = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = IDX_W'((int'(last_idx_q) + i) % NUM_REQ);
         if (!found && i_Req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign sel_seed = i_Seed[int'(pick)*NUM_BITS +: NUM_BITS];
   assign sel_len  = i_Len[int'(pick)*LEN_W +: LEN_W];

`ifdef LFSR_BURST_ABORT_EN
   assign abort = (state_q == RUN) && !i_Req[idx_q];
`else
   assign abort = 1'b0;
`endif

   assign hs               = o_Data_Valid && i_Data_Ready;
   assign o_Data           = i_LFSR_Data;
   assign o_LFSR_Seed_Data = seed_q;
   assign o_Busy           = (state_q != IDLE);

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      last_idx_d     = last_idx_q;
      seed_d         = seed_q;
      last_cnt_d     = last_cnt_q;
      cnt_d          = cnt_q;
      o_Grant        = '0;
      o_Data_Valid   = 1'b0;
      o_Last         = 1'b0;
      o_LFSR_Enable  = 1'b0;
      o_LFSR_Seed_DV = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               idx_d      = pick;
               last_idx_d = pick;
               seed_d     = sel_seed;
               // Zero length behaves as a single word
               last_cnt_d = (sel_len == '0) ? '0 : sel_len - 1'b1;
               cnt_d      = '0;
               state_d    = SEED;
            end
         end
         SEED: begin
            o_Grant[idx_q] = 1'b1;
            o_LFSR_Enable  = 1'b1;
            o_LFSR_Seed_DV = 1'b1;
            state_d        = RUN;
         end
         RUN: begin
            o_Grant[idx_q] = 1'b1;
            if (abort) begin
               state_d = IDLE;
            end else begin
               o_Data_Valid = 1'b1;
               o_Last       = (cnt_q == last_cnt_q);
               if (i_Data_Ready) begin
                  o_LFSR_Enable = 1'b1;
                  cnt_d         = cnt_q + 1'b1;
                  if (o_Last) state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         last_idx_q <= IDX_W'(NUM_REQ - 1);
         seed_q     <= '0;
         last_cnt_q <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         last_idx_q <= last_idx_d;
         seed_q     <= seed_d;
         last_cnt_q <= last_cnt_d;
         cnt_q      <= cnt_d;
      end
   end

   logic unused_hs;
   assign unused_hs = hs;

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Bench for lfsr_burst_ctrl with an attached 8-bit XNOR LFSR.
// Directed scenarios plus randomized bursts against a transaction model.
module tb_lfsr_burst_ctrl;
   localparam int NB = 8;
   localparam int NR = 4;
   localparam int LW = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NR-1:0]    req = '0;
   logic [NR*NB-1:0] seed = '0;
   logic [NR*LW-1:0] len = '0;
   logic             ready = 1'b0;
   logic [NR-1:0]    o_Grant;
   logic             o_Busy;
   logic [NB-1:0]    o_Data;
   logic             o_Data_Valid;
   logic             o_Last;
   logic             o_LFSR_Enable;
   logic             o_LFSR_Seed_DV;
   logic [NB-1:0]    o_LFSR_Seed_Data;
   logic [NB-1:0]    lfsr_q = 8'h00;

   int checks = 0;
   int passes = 0;
   int m_last = NR - 1;

   always #5 clk = ~clk;

   lfsr_burst_ctrl #(.NUM_BITS(NB), .NUM_REQ(NR), .LEN_W(LW)) dut (
      .i_Clk(clk),
      .i_Rst_L(rst_n),
      .i_Req(req),
      .i_Seed(seed),
      .i_Len(len),
      .o_Grant(o_Grant),
      .o_Busy(o_Busy),
      .o_Data(o_Data),
      .o_Data_Valid(o_Data_Valid),
      .i_Data_Ready(ready),
      .o_Last(o_Last),
      .o_LFSR_Enable(o_LFSR_Enable),
      .o_LFSR_Seed_DV(o_LFSR_Seed_DV),
      .o_LFSR_Seed_Data(o_LFSR_Seed_Data),
      .i_LFSR_Data(lfsr_q)
   );

   function automatic logic [7:0] lfsr_next(input logic [7:0] x);
      return {x[6:0], ~(x[7] ^ x[5] ^ x[4] ^ x[3])};
   endfunction

   // Attached LFSR: enable+seed_dv loads, enable alone shifts
   always @(posedge clk)
      if (o_LFSR_Enable)
         lfsr_q <= o_LFSR_Seed_DV ? o_LFSR_Seed_Data : lfsr_next(lfsr_q);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      m_last = NR - 1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req = '1;
      ready = 1'b1;
      repeat (2) step();
      @(negedge clk);
      checks++;
      if ({o_Grant, o_Busy, o_Data_Valid, o_Last, o_LFSR_Enable,
           o_LFSR_Seed_DV, o_LFSR_Seed_Data} !== '0)
         $display("FAIL reset_outputs got grant=%b busy=%b v=%b last=%b en=%b dv=%b sd=%h exp all 0",
                  o_Grant, o_Busy, o_Data_Valid, o_Last, o_LFSR_Enable,
                  o_LFSR_Seed_DV, o_LFSR_Seed_Data);
      else passes++;
      step();
      req = '0;
      rst_n = 1'b1;
      m_last = NR - 1;
   endtask

   task automatic test_single_burst();
      logic [7:0] exp_w [3];
      exp_w[0] = 8'h01;
      exp_w[1] = 8'h03;
      exp_w[2] = 8'h07;
      req = 4'b0001;
      seed[7:0] = 8'h01;
      len[7:0] = 8'd3;
      ready = 1'b1;
      @(negedge clk);
      checks++;
      if (o_Busy !== 1'b0) $display("FAIL sb_idle0 got busy=%b exp 0", o_Busy);
      else passes++;
      step();
      @(negedge clk);
      checks++;
      if ({o_Grant, o_LFSR_Seed_DV, o_LFSR_Enable, o_LFSR_Seed_Data}
          !== {4'b0001, 1'b1, 1'b1, 8'h01})
         $display("FAIL sb_seed got grant=%b dv=%b en=%b sd=%h exp 0001 1 1 01",
                  o_Grant, o_LFSR_Seed_DV, o_LFSR_Enable, o_LFSR_Seed_Data);
      else passes++;
      step();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({o_Data_Valid, o_Data, o_Last} !== {1'b1, exp_w[i], (i == 2)})
            $display("FAIL sb_word%0d got v=%b d=%h last=%b exp 1 %h %b",
                     i, o_Data_Valid, o_Data, o_Last, exp_w[i], (i == 2));
         else passes++;
         step();
      end
      req = '0;
      @(negedge clk);
      checks++;
      if ({o_Busy, o_Data_Valid} !== 2'b00)
         $display("FAIL sb_idle5 got busy=%b v=%b exp 0 0", o_Busy, o_Data_Valid);
      else passes++;
      step();
      m_last = 0;
   endtask

   task automatic test_backpressure();
      logic [7:0] w;
      int k;
      req = 4'b0001;
      seed[7:0] = 8'h01;
      len[7:0] = 8'd3;
      ready = 1'b1;
      step();
      @(negedge clk);
      checks++;
      if (o_Grant !== 4'b0001)
         $display("FAIL bp_grant got %b exp 0001", o_Grant);
      else passes++;
      step();
      w = 8'h01;
      k = 0;
      for (int c = 0; c < 20 && k < 3; c++) begin
         ready = (c >= 1 && c <= 3) ? 1'b0 : 1'b1;
         @(negedge clk);
         checks++;
         if ({o_Data_Valid, o_Data, o_Last, o_LFSR_Enable}
             !== {1'b1, w, (k == 2), ready})
            $display("FAIL bp_cycle%0d got v=%b d=%h last=%b en=%b exp 1 %h %b %b",
                     c, o_Data_Valid, o_Data, o_Last, o_LFSR_Enable,
                     w, (k == 2), ready);
         else passes++;
         if (ready) begin
            w = lfsr_next(w);
            k++;
         end
         step();
      end
      req = '0;
      ready = 1'b1;
      @(negedge clk);
      checks++;
      if (o_Busy !== 1'b0 || k != 3)
         $display("FAIL bp_done got busy=%b words=%0d exp 0 3", o_Busy, k);
      else passes++;
      step();
      m_last = 0;
   endtask

   task automatic test_round_robin();
      int exp_order [5];
      int g;
      exp_order = '{0, 1, 3, 0, 1};
      g = 0;
      do_reset();
      req = 4'b1011;
      len = {4{8'd1}};
      ready = 1'b1;
      for (int cyc = 0; cyc < 15; cyc++) begin
         @(negedge clk);
         checks++;
         if ({o_Busy, o_LFSR_Seed_DV, o_Data_Valid}
             !== {(cyc % 3 != 0), (cyc % 3 == 1), (cyc % 3 == 2)})
            $display("FAIL rr_phase%0d got busy=%b dv=%b v=%b", cyc,
                     o_Busy, o_LFSR_Seed_DV, o_Data_Valid);
         else passes++;
         if (o_LFSR_Seed_DV === 1'b1 && g < 5) begin
            checks++;
            if (o_Grant !== (4'b0001 << exp_order[g]))
               $display("FAIL rr_grant%0d got %b exp %b", g, o_Grant,
                        4'b0001 << exp_order[g]);
            else passes++;
            g++;
         end
         step();
      end
      req = '0;
      checks++;
      if (g != 5) $display("FAIL rr_count got %0d exp 5", g);
      else passes++;
      step();
      m_last = 1;
   endtask

   task automatic test_zero_length();
      logic [7:0] s;
      s = 8'($urandom);
      req = 4'b0100;
      seed[23:16] = s;
      len[23:16] = 8'd0;
      ready = 1'b1;
      step();
      @(negedge clk);
      checks++;
      if (o_Grant !== 4'b0100) $display("FAIL zl_grant got %b exp 0100", o_Grant);
      else passes++;
      step();
      @(negedge clk);
      checks++;
      if ({o_Data_Valid, o_Data, o_Last} !== {1'b1, s, 1'b1})
         $display("FAIL zl_word got v=%b d=%h last=%b exp 1 %h 1",
                  o_Data_Valid, o_Data, o_Last, s);
      else passes++;
      step();
      req = '0;
      @(negedge clk);
      checks++;
      if (o_Busy !== 1'b0) $display("FAIL zl_idle got busy=%b exp 0", o_Busy);
      else passes++;
      step();
      m_last = 2;
   endtask

   task automatic test_async_reset();
      logic [7:0] s1;
      req = 4'b0001;
      seed[7:0] = 8'($urandom) | 8'h01;
      len[7:0] = 8'd10;
      ready = 1'b1;
      repeat (3) step();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({o_Grant, o_Busy, o_Data_Valid, o_Last, o_LFSR_Enable,
           o_LFSR_Seed_DV, o_LFSR_Seed_Data} !== '0)
         $display("FAIL ar_clear got grant=%b busy=%b v=%b last=%b en=%b dv=%b sd=%h exp all 0",
                  o_Grant, o_Busy, o_Data_Valid, o_Last, o_LFSR_Enable,
                  o_LFSR_Seed_DV, o_LFSR_Seed_Data);
      else passes++;
      s1 = 8'($urandom);
      req = 4'b0010;
      seed[15:8] = s1;
      len[15:8] = 8'd1;
      step();
      rst_n = 1'b1;
      m_last = NR - 1;
      step();
      @(negedge clk);
      checks++;
      if (o_Grant !== 4'b0010) $display("FAIL ar_grant got %b exp 0010", o_Grant);
      else passes++;
      step();
      @(negedge clk);
      checks++;
      if ({o_Data_Valid, o_Data} !== {1'b1, s1})
         $display("FAIL ar_word got v=%b d=%h exp 1 %h", o_Data_Valid, o_Data, s1);
      else passes++;
      step();
      req = '0;
      step();
      m_last = 1;
   endtask

`ifdef LFSR_BURST_ABORT_EN
   task automatic test_abort();
      logic [7:0] s0, s1, w;
      s0 = 8'($urandom);
      s1 = 8'($urandom);
      req = 4'b0011;
      seed[7:0] = s0;
      seed[15:8] = s1;
      len[7:0] = 8'd5;
      len[15:8] = 8'd1;
      ready = 1'b1;
      step();
      @(negedge clk);
      checks++;
      if (o_Grant !== 4'b0001) $display("FAIL ab_grant0 got %b exp 0001", o_Grant);
      else passes++;
      step();
      w = s0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if ({o_Data_Valid, o_Data, o_Last} !== {1'b1, w, 1'b0})
            $display("FAIL ab_word%0d got v=%b d=%h last=%b exp 1 %h 0",
                     i, o_Data_Valid, o_Data, o_Last, w);
         else passes++;
         w = lfsr_next(w);
         step();
      end
      req = 4'b0010;
      @(negedge clk);
      checks++;
      if ({o_Data_Valid, o_Last, o_LFSR_Enable} !== 3'b000)
         $display("FAIL ab_drop got v=%b last=%b en=%b exp 000",
                  o_Data_Valid, o_Last, o_LFSR_Enable);
      else passes++;
      step();
      @(negedge clk);
      checks++;
      if (o_Busy !== 1'b0) $display("FAIL ab_idle got busy=%b exp 0", o_Busy);
      else passes++;
      step();
      @(negedge clk);
      checks++;
      if ({o_Grant, o_LFSR_Seed_Data} !== {4'b0010, s1})
         $display("FAIL ab_next got grant=%b sd=%h exp 0010 %h",
                  o_Grant, o_LFSR_Seed_Data, s1);
      else passes++;
      step();
      @(negedge clk);
      checks++;
      if ({o_Data_Valid, o_Data, o_Last} !== {1'b1, s1, 1'b1})
         $display("FAIL ab_next_word got v=%b d=%h last=%b exp 1 %h 1",
                  o_Data_Valid, o_Data, o_Last, s1);
      else passes++;
      step();
      req = '0;
      step();
      m_last = 1;
   endtask
`endif

   task automatic test_random();
      logic [7:0] es, w;
      logic [7:0] el;
      int p, L, k;
      bit found;
      do_reset();
      for (int b = 0; b < 40; b++) begin
         req = NR'($urandom_range(1, (1 << NR) - 1));
         seed = NR*NB'({$urandom});
         for (int r = 0; r < NR; r++) len[r*LW +: LW] = LW'($urandom_range(0, 6));
         found = 0;
         p = 0;
         for (int i = 1; i <= NR; i++) begin
            int c = (m_last + i) % NR;
            if (!found && req[c]) begin
               found = 1;
               p = c;
            end
         end
         es = seed[p*NB +: NB];
         el = len[p*LW +: LW];
         L = (el == 0) ? 1 : int'(el);
         @(negedge clk);
         checks++;
         if (o_Busy !== 1'b0) $display("FAIL rnd%0d_idle got busy=%b exp 0", b, o_Busy);
         else passes++;
         step();
         seed = NR*NB'({$urandom});
         len = NR*LW'({$urandom});
         @(negedge clk);
         checks++;
         if ({o_Grant, o_LFSR_Seed_DV, o_LFSR_Seed_Data}
             !== {4'b0001 << p, 1'b1, es})
            $display("FAIL rnd%0d_seed got grant=%b dv=%b sd=%h exp %b 1 %h",
                     b, o_Grant, o_LFSR_Seed_DV, o_LFSR_Seed_Data, 4'b0001 << p, es);
         else passes++;
         step();
         w = es;
         k = 0;
         for (int c = 0; c < 200 && k < L; c++) begin
            ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if ({o_Data_Valid, o_Data, o_Last, o_LFSR_Enable}
                !== {1'b1, w, (k == L - 1), ready})
               $display("FAIL rnd%0d_w%0d got v=%b d=%h last=%b en=%b exp 1 %h %b %b",
                        b, k, o_Data_Valid, o_Data, o_Last, o_LFSR_Enable,
                        w, (k == L - 1), ready);
            else passes++;
            if (ready) begin
               w = lfsr_next(w);
               k++;
            end
            step();
         end
         checks++;
         if (k != L) $display("FAIL rnd%0d_timeout got %0d words exp %0d", b, k, L);
         else passes++;
         m_last = p;
      end
      req = '0;
      step();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single_burst();
      test_backpressure();
      test_round_robin();
      test_zero_length();
      test_async_reset();
`ifdef LFSR_BURST_ABORT_EN
      test_abort();
`endif
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
